seat_manager: RTL

SEAT_MANAGER -- requirements
Module: seat_manager

---
 rtl/seat_pkg.sv | 36 +++
 rtl/seat_sweeper.sv | 50 +++++
 rtl/seat_manager.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/seat_pkg.sv
// Shared types for the seat manager: seat/op/status encodings and the per-seat record.
package seat_pkg;

  localparam int SID_MAX_W  = 32;
  localparam int TIME_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_FREE     = 2'd0,
    ST_RESERVED = 2'd1,
    ST_OCCUPIED = 2'd2,
    ST_AWAY     = 2'd3
  } seat_state_e;

  typedef enum logic [1:0] {
    OP_RESERVE = 2'd0,
    OP_CHECKIN = 2'd1,
    OP_AWAY    = 2'd2,
    OP_RELEASE = 2'd3
  } req_op_e;

  typedef enum logic [2:0] {
    RS_OK        = 3'd0,
    RS_ERR_RANGE = 3'd1,
    RS_ERR_STATE = 3'd2,
    RS_ERR_OWNER = 3'd3,
    RS_ERR_DUP   = 3'd4
  } rsp_status_e;

  // Fields are sized for the widest supported sid/time; unused upper bits stay zero.
  typedef struct packed {
    seat_state_e             state;
    logic [SID_MAX_W-1:0]    sid;
    logic [TIME_MAX_W-1:0]   ts;
  } seat_rec_t;

endpackage

// File: rtl/seat_sweeper.sv
// Round-robin timeout scanner: visits one seat per cycle and flags stale RESERVED/AWAY seats.
module seat_sweeper
  import seat_pkg::*;
#(
  parameter int NUM_SEATS  = 32,
  parameter int TIME_W     = 11,
  parameter int RES_LIMIT  = 30,
  parameter int AWAY_LIMIT = 60,
  parameter int SEAT_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TIME_W-1:0]     i_cur_time,
  input  logic [1:0]            i_state,
  input  logic [TIME_MAX_W-1:0] i_ts,
  input  logic                  i_block,
  output logic [SEAT_W-1:0]     o_ptr,
  output logic                  o_fire,
  output logic                  o_expire_valid,
  output logic [SEAT_W-1:0]     o_expire_seat
);

  logic [SEAT_W-1:0] r_ptr;
  logic [SEAT_W-1:0] r_exp_seat;
  logic              r_exp_valid;
  logic [TIME_W-1:0] w_age;

  // Age is taken modulo 2^TIME_W so the minute counter may wrap freely.
  assign w_age  = TIME_W'(TIME_MAX_W'(i_cur_time) - i_ts);
  assign o_fire = !i_block &&
                  (((i_state == ST_RESERVED) && (w_age >= TIME_W'(RES_LIMIT))) ||
                   ((i_state == ST_AWAY)     && (w_age >= TIME_W'(AWAY_LIMIT))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= SEAT_W'(1);
      r_exp_valid <= 1'b0;
      r_exp_seat  <= '0;
    end else begin
      r_ptr       <= (r_ptr == SEAT_W'(NUM_SEATS)) ? SEAT_W'(1) : r_ptr + SEAT_W'(1);
      r_exp_valid <= o_fire;
      if (o_fire) r_exp_seat <= r_ptr;
    end
  end

  assign o_ptr          = r_ptr;
  assign o_expire_valid = r_exp_valid;
  assign o_expire_seat  = r_exp_seat;

endmodule

// File: rtl/seat_manager.sv
// Seat reservation table with IDLE->EXEC->RESP request FSM.
// Optional timeout sweeping is enabled by defining SEAT_TIMEOUT_EN.
module seat_manager #(
  parameter int NUM_SEATS  = 32,
  parameter int SID_W      = 25,
  parameter int TIME_W     = 11,
  parameter int RES_LIMIT  = 30,
  parameter int AWAY_LIMIT = 60,
  localparam int SEAT_W    = $clog2(NUM_SEATS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TIME_W-1:0] cur_time,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [SID_W-1:0]  req_sid,
  input  logic [SEAT_W-1:0] req_seat,
  output logic              rsp_valid,
  output logic [2:0]        rsp_status,
  output logic [1:0]        rsp_state,
  output logic [SEAT_W-1:0] free_cnt,
  output logic              expire_valid,
  output logic [SEAT_W-1:0] expire_seat
);
  import seat_pkg::*;

  typedef enum logic [1:0] {C_IDLE, C_EXEC, C_RESP} ctrl_e;

  ctrl_e             r_ctrl, w_ctrl_nxt;
  req_op_e           r_op;
  logic [SID_W-1:0]  r_sid;
  logic [SEAT_W-1:0] r_seat;
  seat_rec_t         r_tbl [NUM_SEATS];
  logic              r_rsp_valid;
  rsp_status_e       r_rsp_status;
  seat_state_e       r_rsp_state;
  logic [SEAT_W-1:0] r_free_cnt;

  logic                 w_accept, w_in_range, w_own, w_dup, w_wr;
  logic [SID_MAX_W-1:0] w_sid_ext;
  seat_rec_t            w_cur, w_new;
  rsp_status_e          w_status;
  logic [SEAT_W-1:0]    w_free;
  logic [SEAT_W-1:0]    w_sw_ptr;
  logic                 w_sw_fire;

  // Ready is forced low while reset is held, not just after the first clock.
  assign req_ready = (r_ctrl == C_IDLE) && rst_n;
  assign w_accept  = req_valid && req_ready;
  assign w_sid_ext = SID_MAX_W'(r_sid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ctrl <= C_IDLE;
    else        r_ctrl <= w_ctrl_nxt;
  end

  always_comb begin
    w_ctrl_nxt = r_ctrl;
    case (r_ctrl)
      C_IDLE:  if (w_accept) w_ctrl_nxt = C_EXEC;
      C_EXEC:  w_ctrl_nxt = C_RESP;
      default: w_ctrl_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op   <= req_op_e'(req_op);
      r_sid  <= req_sid;
      r_seat <= req_seat;
    end
  end

  // Out-of-range seats never match a table index, so w_cur reads back as FREE/0.
  always_comb begin
    w_in_range = (r_seat != '0) && (r_seat <= SEAT_W'(NUM_SEATS));
    w_cur      = '0;
    w_dup      = 1'b0;
    for (int i = 0; i < NUM_SEATS; i++) begin
      if (r_seat == SEAT_W'(i + 1)) w_cur = r_tbl[i];
      if ((r_tbl[i].state != ST_FREE) && (r_tbl[i].sid == w_sid_ext)) w_dup = 1'b1;
    end
    w_own    = (w_cur.sid == w_sid_ext);
    w_new    = w_cur;
    w_status = RS_OK;
    if (!w_in_range) begin
      w_status = RS_ERR_RANGE;
    end else begin
      case (r_op)
        OP_RESERVE: begin
          if (w_cur.state != ST_FREE) w_status = RS_ERR_STATE;
          else if (w_dup)             w_status = RS_ERR_DUP;
          else begin
            w_new.state = ST_RESERVED;
            w_new.sid   = w_sid_ext;
            w_new.ts    = TIME_MAX_W'(cur_time);
          end
        end
        OP_CHECKIN: begin
          if ((w_cur.state != ST_RESERVED) && (w_cur.state != ST_AWAY)) w_status = RS_ERR_STATE;
          else if (!w_own) w_status = RS_ERR_OWNER;
          else             w_new.state = ST_OCCUPIED;
        end
        OP_AWAY: begin
          if (w_cur.state != ST_OCCUPIED) w_status = RS_ERR_STATE;
          else if (!w_own)                w_status = RS_ERR_OWNER;
          else begin
            w_new.state = ST_AWAY;
            w_new.ts    = TIME_MAX_W'(cur_time);
          end
        end
        default: begin
          if (w_cur.state == ST_FREE) w_status = RS_ERR_STATE;
          else if (!w_own)            w_status = RS_ERR_OWNER;
          else begin
            w_new.state = ST_FREE;
            w_new.sid   = '0;
          end
        end
      endcase
    end
    w_wr = (r_ctrl == C_EXEC) && (w_status == RS_OK);
  end

  // A request write takes priority; the sweeper is blocked on that seat anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SEATS; i++) r_tbl[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SEATS; i++) begin
        if (w_wr && (r_seat == SEAT_W'(i + 1)))              r_tbl[i] <= w_new;
        else if (w_sw_fire && (w_sw_ptr == SEAT_W'(i + 1)))  r_tbl[i] <= '0;
      end
    end
  end

  always_comb begin
    w_free = '0;
    for (int i = 0; i < NUM_SEATS; i++)
      if (r_tbl[i].state == ST_FREE) w_free = w_free + SEAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= RS_OK;
      r_rsp_state  <= ST_FREE;
      r_free_cnt   <= SEAT_W'(NUM_SEATS);
    end else begin
      r_rsp_valid <= (r_ctrl == C_EXEC);
      if (r_ctrl == C_EXEC) begin
        r_rsp_status <= w_status;
        r_rsp_state  <= w_new.state;
      end
      r_free_cnt <= w_free;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_status = r_rsp_status;
  assign rsp_state  = r_rsp_state;
  assign free_cnt   = r_free_cnt;

`ifdef SEAT_TIMEOUT_EN
  logic [1:0]            w_sw_state;
  logic [TIME_MAX_W-1:0] w_sw_ts;
  logic                  w_sw_block;

  always_comb begin
    w_sw_state = '0;
    w_sw_ts    = '0;
    for (int i = 0; i < NUM_SEATS; i++) begin
      if (w_sw_ptr == SEAT_W'(i + 1)) begin
        w_sw_state = r_tbl[i].state;
        w_sw_ts    = r_tbl[i].ts;
      end
    end
  end

  assign w_sw_block = (r_ctrl == C_EXEC) && (r_seat == w_sw_ptr);

  seat_sweeper #(
    .NUM_SEATS (NUM_SEATS),
    .TIME_W    (TIME_W),
    .RES_LIMIT (RES_LIMIT),
    .AWAY_LIMIT(AWAY_LIMIT),
    .SEAT_W    (SEAT_W)
  ) u_sweeper (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cur_time    (cur_time),
    .i_state       (w_sw_state),
    .i_ts          (w_sw_ts),
    .i_block       (w_sw_block),
    .o_ptr         (w_sw_ptr),
    .o_fire        (w_sw_fire),
    .o_expire_valid(expire_valid),
    .o_expire_seat (expire_seat)
  );
`else
  assign w_sw_ptr     = '0;
  assign w_sw_fire    = 1'b0;
  assign expire_valid = 1'b0;
  assign expire_seat  = '0;
`endif

endmodule
